// File: rtl/src_pp_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : src_pp_buf_if
// Brief    : DMA-fill / exec-read bundle for the ping-pong source buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface src_pp_buf_if #(
    parameter int DW    = 64,
    parameter int LW    = 32,
    parameter int DEPTH = 16
);
    localparam int c_lanes = DW / LW;
    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_la    = $clog2(c_lanes);

    logic                   src_v;
    logic [c_aw-1:0]        src_a;
    logic [DW-1:0]          src_d;
    logic                   src_last;
    logic                   src_rdy;
    logic                   exec;
    logic [c_aw+c_la-1:0]   ia;
    logic [LW-1:0]          d;
    logic                   exec_rdy;
    logic                   exec_done;
    logic [1:0]             nfull;
    logic                   err_ovf;
    logic                   err_udf;

    modport master (
        output src_v, src_a, src_d, src_last, exec, ia, exec_done,
        input  src_rdy, d, exec_rdy, nfull, err_ovf, err_udf
    );

    modport slave (
        input  src_v, src_a, src_d, src_last, exec, ia, exec_done,
        output src_rdy, d, exec_rdy, nfull, err_ovf, err_udf
    );
endinterface
`default_nettype wire

// File: rtl/src_pp_buf.sv
`default_nettype none
// ============================================================================
// Module   : src_pp_buf
// Brief    : Ping-pong source buffer; DMA fills one bank while exec reads
//            LW-bit lanes from the other, banks handed over by fill/release.
// Revision : 1.0 - initial release
// ============================================================================
module src_pp_buf #(
    parameter int DW    = 64,
    parameter int LW    = 32,
    parameter int DEPTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    src_pp_buf_if.slave     bus
);
    localparam int c_lanes = DW / LW;
    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_la    = $clog2(c_lanes);

    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } bank_st_t;

    bank_st_t           r_bank_st [2];
    bank_st_t           w_bank_st_nxt [2];
    logic               r_wb;
    logic               r_rb;
    logic               w_wb_nxt;
    logic               w_rb_nxt;
    logic [DW-1:0]      r_mem [2][DEPTH];
    logic [DW-1:0]      r_word;
    logic [c_la-1:0]    r_lane;
    logic               r_err_ovf;
    logic               r_err_udf;
    logic               w_src_rdy;
    logic               w_exec_rdy;
    logic               w_wr;
    logic               w_rd;
    logic               w_rel;
    logic [LW-1:0]      w_lanes [c_lanes];

    assign w_src_rdy  = (r_bank_st[r_wb] == FREE);
    assign w_exec_rdy = (r_bank_st[r_rb] == FULL);
    assign w_wr       = bus.src_v & w_src_rdy;
    assign w_rd       = bus.exec & w_exec_rdy;
    assign w_rel      = bus.exec_done & w_exec_rdy;

    assign bus.src_rdy  = w_src_rdy;
    assign bus.exec_rdy = w_exec_rdy;
    assign bus.nfull    = {1'b0, r_bank_st[0] == FULL} + {1'b0, r_bank_st[1] == FULL};
    assign bus.err_ovf  = r_err_ovf;
    assign bus.err_udf  = r_err_udf;

    // A completing fill and a release always target different banks
    // (one must be FREE, the other FULL), so both updates can apply at once.
    always_comb begin
        w_bank_st_nxt = r_bank_st;
        w_wb_nxt      = r_wb;
        w_rb_nxt      = r_rb;
        if (w_wr && bus.src_last) begin
            w_bank_st_nxt[r_wb] = FULL;
            w_wb_nxt            = ~r_wb;
        end
        if (w_rel) begin
            w_bank_st_nxt[r_rb] = FREE;
            w_rb_nxt            = ~r_rb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_st[0] <= FREE;
            r_bank_st[1] <= FREE;
            r_wb         <= 1'b0;
            r_rb         <= 1'b0;
        end else begin
            r_bank_st <= w_bank_st_nxt;
            r_wb      <= w_wb_nxt;
            r_rb      <= w_rb_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_err_ovf <= r_err_ovf | (bus.src_v & ~w_src_rdy);
            r_err_udf <= r_err_udf | ((bus.exec | bus.exec_done) & ~w_exec_rdy);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wb][bus.src_a] <= bus.src_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (w_rd) begin
            r_word <= r_mem[r_rb][bus.ia[c_aw+c_la-1:c_la]];
            r_lane <= bus.ia[c_la-1:0];
        end
    end

    // Lane 0 is the most significant slice of the word.
    for (genvar g = 0; g < c_lanes; g++) begin : g_lanes
        assign w_lanes[g] = r_word[DW-1-g*LW -: LW];
    end

    assign bus.d = w_lanes[r_lane];
endmodule
`default_nettype wire

// File: tb/tb_src_pp_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_src_pp_buf
// Brief    : Self-checking bench; two configurations (64/32/16, 128/32/8)
//            driven in lockstep against a bank-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_src_pp_buf;
    localparam int c_n_rand = 3000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    src_pp_buf_if #(.DW(64),  .LW(32), .DEPTH(16)) bus0 ();
    src_pp_buf_if #(.DW(128), .LW(32), .DEPTH(8))  bus1 ();

    src_pp_buf #(.DW(64),  .LW(32), .DEPTH(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    src_pp_buf #(.DW(128), .LW(32), .DEPTH(8))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        bit           v;
        int           a;
        logic [127:0] dat;
        bit           last;
        bit           ex;
        int           ia;
        bit           done;
    } stim_t;

    stim_t        s [2];
    logic [127:0] m_mem  [2][2][16];
    bit           m_vld  [2][2][16];
    bit           m_full [2][2];
    bit           m_wb   [2];
    bit           m_rb   [2];
    logic [31:0]  m_d    [2];
    bit           m_dv   [2];
    bit           m_ovf  [2];
    bit           m_udf  [2];
    int           n_cmp = 0;
    int           n_mis = 0;

    function automatic int depth(input int k); return (k == 0) ? 16 : 8;  endfunction
    function automatic int lanes(input int k); return (k == 0) ? 2  : 4;  endfunction
    function automatic int dw(input int k);    return (k == 0) ? 64 : 128; endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            s[k].v = 0; s[k].a = 0; s[k].dat = '0; s[k].last = 0;
            s[k].ex = 0; s[k].ia = 0; s[k].done = 0;
        end
    endtask

    task automatic drive();
        bus0.src_v = s[0].v; bus0.src_a = 4'(s[0].a); bus0.src_d = s[0].dat[63:0];
        bus0.src_last = s[0].last; bus0.exec = s[0].ex; bus0.ia = 5'(s[0].ia);
        bus0.exec_done = s[0].done;
        bus1.src_v = s[1].v; bus1.src_a = 3'(s[1].a); bus1.src_d = s[1].dat;
        bus1.src_last = s[1].last; bus1.exec = s[1].ex; bus1.ia = 5'(s[1].ia);
        bus1.exec_done = s[1].done;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_full[k][0] = 0; m_full[k][1] = 0; m_wb[k] = 0; m_rb[k] = 0;
            m_d[k] = '0; m_dv[k] = 1; m_ovf[k] = 0; m_udf[k] = 0;
        end
    endtask

    // Effect of one rising edge on configuration k, from the current stimulus.
    task automatic model_edge(input int k);
        int           wrd;
        int           lane;
        bit           wr_ok;
        bit           rd_ok;
        logic [127:0] dat;
        logic [127:0] word;
        wr_ok = !m_full[k][m_wb[k]];
        rd_ok = m_full[k][m_rb[k]];
        dat   = (k == 0) ? {64'd0, s[k].dat[63:0]} : s[k].dat;
        if (s[k].ex) begin
            if (rd_ok) begin
                wrd     = s[k].ia / lanes(k);
                lane    = s[k].ia % lanes(k);
                word    = m_mem[k][m_rb[k]][wrd];
                m_d[k]  = 32'(word >> (dw(k) - 32 * (lane + 1)));
                m_dv[k] = m_vld[k][m_rb[k]][wrd];
            end else begin
                m_udf[k] = 1;
            end
        end
        if (s[k].v) begin
            if (wr_ok) begin
                m_mem[k][m_wb[k]][s[k].a] = dat;
                m_vld[k][m_wb[k]][s[k].a] = 1;
                if (s[k].last) begin
                    m_full[k][m_wb[k]] = 1;
                    m_wb[k] = !m_wb[k];
                end
            end else begin
                m_ovf[k] = 1;
            end
        end
        if (s[k].done) begin
            if (rd_ok) begin
                m_full[k][m_rb[k]] = 0;
                m_rb[k] = !m_rb[k];
            end else begin
                m_udf[k] = 1;
            end
        end
    endtask

    task automatic check_outs();
        logic [31:0] gd  [2];
        logic        gsr [2];
        logic        ger [2];
        logic        gov [2];
        logic        gud [2];
        logic [1:0]  gnf [2];
        gd[0] = bus0.d; gsr[0] = bus0.src_rdy; ger[0] = bus0.exec_rdy;
        gov[0] = bus0.err_ovf; gud[0] = bus0.err_udf; gnf[0] = bus0.nfull;
        gd[1] = bus1.d; gsr[1] = bus1.src_rdy; ger[1] = bus1.exec_rdy;
        gov[1] = bus1.err_ovf; gud[1] = bus1.err_udf; gnf[1] = bus1.nfull;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("i%0d src_rdy", k), 64'(gsr[k]), 64'(!m_full[k][m_wb[k]]));
            chk($sformatf("i%0d exec_rdy", k), 64'(ger[k]), 64'(m_full[k][m_rb[k]]));
            chk($sformatf("i%0d nfull", k), 64'(gnf[k]), 64'(m_full[k][0]) + 64'(m_full[k][1]));
            chk($sformatf("i%0d err_ovf", k), 64'(gov[k]), 64'(m_ovf[k]));
            chk($sformatf("i%0d err_udf", k), 64'(gud[k]), 64'(m_udf[k]));
            if (m_dv[k]) chk($sformatf("i%0d d", k), 64'(gd[k]), 64'(m_d[k]));
        end
    endtask

    task automatic tick();
        drive();
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_outs();
    endtask

    // Reset asserted asynchronously while a write, read and fill-complete are in flight.
    task automatic do_reset();
        idle();
        for (int k = 0; k < 2; k++) begin
            s[k].v = 1; s[k].a = 1; s[k].dat = {4{$urandom}}; s[k].last = 1;
            s[k].ex = 1; s[k].ia = 3;
        end
        drive();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outs();
        idle();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        drive();
        model_reset();
        repeat (2) @(negedge clk);
        check_outs();
        rst_n = 1'b1;
        @(negedge clk);

        // Fill bank 0 with per-lane patterns
        for (int a = 0; a < 16; a++) begin
            idle();
            s[0].v = 1; s[0].a = a; s[0].last = (a == 15);
            s[0].dat = {64'd0, 32'(a), 32'(a + 16)};
            if (a < 8) begin
                s[1].v = 1; s[1].a = a; s[1].last = (a == 7);
                s[1].dat = {32'(a), 32'(a + 16), 32'(a + 32), 32'(a + 48)};
            end
            tick();
        end
        chk("fill nfull", 64'(bus0.nfull), 64'd1);
        idle();
        s[0].ex = 1; s[0].ia = 6; s[1].ex = 1; s[1].ia = 15;
        tick();
        chk("i0 word3 lane0", 64'(bus0.d), 64'h3);
        chk("i1 word3 lane3", 64'(bus1.d), 64'h33);
        s[0].ia = 7; s[1].ia = 12;
        tick();
        chk("i0 word3 lane1", 64'(bus0.d), 64'h13);
        chk("i1 word3 lane0", 64'(bus1.d), 64'h3);

        // Fill bank 1 while reading bank 0
        for (int a = 0; a < 16; a++) begin
            idle();
            s[0].v = 1; s[0].a = a; s[0].last = (a == 15); s[0].dat = {4{$urandom}};
            s[0].ex = 1; s[0].ia = $urandom % 32;
            if (a < 8) begin
                s[1].v = 1; s[1].a = a; s[1].last = (a == 7); s[1].dat = {4{$urandom}};
            end
            s[1].ex = 1; s[1].ia = $urandom % 32;
            tick();
        end
        chk("both full nfull", 64'(bus0.nfull), 64'd2);
        chk("both full src_rdy", 64'(bus0.src_rdy), 64'd0);

        // Overflow write must be dropped
        idle();
        for (int k = 0; k < 2; k++) begin
            s[k].v = 1; s[k].a = 2; s[k].dat = {4{$urandom}};
        end
        tick();
        chk("ovf flag", 64'(bus1.err_ovf), 64'd1);
        for (int l = 0; l < 4; l++) begin
            idle();
            s[0].ex = 1; s[0].ia = 4 + (l % 2);
            s[1].ex = 1; s[1].ia = 8 + l;
            tick();
        end

        // Release bank 0, then read bank 1
        idle();
        s[0].done = 1; s[1].done = 1;
        tick();
        chk("release src_rdy", 64'(bus0.src_rdy), 64'd1);
        for (int l = 0; l < 4; l++) begin
            idle();
            s[0].ex = 1; s[0].ia = $urandom % 32;
            s[1].ex = 1; s[1].ia = $urandom % 32;
            tick();
        end

        // Read+release bank 1 while completing a fill of bank 0
        idle();
        for (int k = 0; k < 2; k++) begin
            s[k].v = 1; s[k].a = 0; s[k].last = 1; s[k].dat = {4{$urandom}};
            s[k].ex = 1; s[k].ia = $urandom % 32; s[k].done = 1;
        end
        tick();
        chk("simul nfull", 64'(bus1.nfull), 64'd1);
        chk("simul exec_rdy", 64'(bus1.exec_rdy), 64'd1);

        // Underflow straight after reset
        do_reset();
        idle();
        s[0].ex = 1; s[0].done = 1; s[1].ex = 1; s[1].done = 1; s[1].ia = 9;
        tick();
        chk("udf flag", 64'(bus0.err_udf), 64'd1);
        chk("udf d held", 64'(bus1.d), 64'd0);

        for (int i = 0; i < c_n_rand; i++) begin
            if (i % 1000 == 999) do_reset();
            for (int k = 0; k < 2; k++) begin
                s[k].v    = ($urandom % 4) != 0;
                s[k].a    = $urandom % depth(k);
                s[k].dat  = {$urandom, $urandom, $urandom, $urandom};
                s[k].last = ($urandom % 5) == 0;
                s[k].ex   = ($urandom % 2) != 0;
                s[k].ia   = $urandom % 32;
                s[k].done = ($urandom % 6) == 0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
